alu_exec_stage: RTL and testbench
=================================

ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width; multiply iteration count equals WIDTH.
REQ-002 Parameter ADDR_W, default 3: register address width (8 registers).
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 instValid  in  1  instruction offered this cycle.
REQ-006 instReady  out  1  stage can accept an instruction this cycle.
REQ-007 op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 SLT.
REQ-008 dst, srcA, srcB  in  ADDR_W each  destination and source register numbers.
REQ-009 readAddrA, readAddrB  out  ADDR_W each  registered read addresses to the register file.
REQ-010 rdA, rdB  in  WIDTH each  combinational read data from the register file.
REQ-011 writeEnable  out  1  register-file write strobe.
REQ-012 writeAddr  out  ADDR_W  write address.
REQ-013 writeData  out  WIDTH  write data.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse, coincident with writeEnable.

Function
REQ-016 FSM states: IDLE, READ, EXEC, WRITE; instReady SHALL be 1 only in IDLE.
REQ-017 Accept on posedge with instValid && instReady: latch op and dst, load readAddrA<=srcA, readAddrB<=srcB, go to READ.
REQ-018 READ (one cycle): at the next posedge, latch opA<=rdA and opB<=rdB, clear the iteration counter, go to EXEC.
REQ-019 EXEC for a non-MUL op: one cycle; at the posedge, register result into writeData and dst into writeAddr, go to WRITE.
REQ-020 EXEC for MUL: shift-add, one multiplier bit per cycle, 5-bit counter 0..WIDTH-1; after WIDTH cycles, register the low WIDTH bits of the product and go to WRITE.
REQ-021 WRITE: writeEnable=1 and done=1 for exactly one cycle, then go to IDLE.
REQ-022 Latency, accept edge = E0: non-MUL writeEnable high between E2 and E3; MUL writeEnable high between E33 and E34.
REQ-023 ADD/SUB/MUL wrap modulo 2^WIDTH; no carry or overflow output.
REQ-024 SHL shifts opA left by opB[4:0] with zero fill; SLT writes 1 if signed opA < signed opB, else 0.
REQ-025 Writes to register 0 SHALL be performed normally; register 0 is not hardwired.
REQ-026 instValid outside IDLE SHALL be ignored with no state change; the source must hold it until accepted.
REQ-027 No forwarding: the earliest next accept is E4, so its READ observes the value written at E3.
REQ-028 writeAddr, writeData, readAddrA and readAddrB SHALL hold their last values when not being updated.
REQ-029 srcA == srcB == dst SHALL be legal and SHALL use pre-write operand values.

Reset
REQ-030 On reset: state=IDLE, counter=0, writeEnable=0, done=0, busy=0, instReady=1, and all address and data outputs = 0.
REQ-031 Reset SHALL take priority over all other activity in every state; a reset during READ, EXEC or MUL iteration aborts the instruction with no write.
REQ-032 An instValid present in the reset cycle SHALL NOT be accepted.

Verification
REQ-033 Regs r0=FEDCBA98, r1=12345678; ADD dst=2 src 0,1 -> writeEnable high in cycle 3 only, writeAddr=2, writeData=11111110, done pulse.
REQ-034 r3=5, r4=7: SUB dst=5 -> FFFFFFFE; SLT r3,r4 -> 00000001; SLT with r3=80000000, r4=1 -> 00000001.
REQ-035 MUL r6=0000FFFF, r7=0000FFFF, dst=6 -> busy for 34 cycles; writeEnable only in cycle 34; writeData=FFFE0001.
REQ-036 Assert reset at MUL iteration 10 -> writeEnable never asserted; instReady=1 in the cycle after reset; all outputs at their reset values.
REQ-037 Back-to-back ADD r2<=r0+r1 then ADD r3<=r2+r2 with instValid held high -> second accept at E4; r3=22222220.
REQ-038 instValid pulsed high during EXEC and then dropped -> no accept and no extra writeEnable.

Source files
------------

// File: rtl/alu_exec_stage.sv
// Multi-cycle ALU execute stage: IDLE -> READ -> EXEC -> WRITE.
// MUL uses a shift-add loop, one multiplier bit per cycle.
module alu_exec_stage #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instValid,
  output logic              instReady,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [ADDR_W-1:0] readAddrA,
  output logic [ADDR_W-1:0] readAddrB,
  input  logic [WIDTH-1:0]  rdA,
  input  logic [WIDTH-1:0]  rdB,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [WIDTH-1:0]  writeData,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] EXEC  = 2'd2;
  localparam logic [1:0] WRITE = 2'd3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        next_state;
  logic [2:0]        op_lat;
  logic [ADDR_W-1:0] dst_lat;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  cnt;
  logic [WIDTH-1:0]  mul_step;
  logic [WIDTH-1:0]  alu_result;
  logic              mul_running;

  // MUL keeps iterating until the last multiplier bit has been folded in
  assign mul_running = (op_lat == OP_MUL) && (cnt != CNT_LAST);

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (instValid) next_state = READ;
        else           next_state = IDLE;
      end
      READ: next_state = EXEC;
      EXEC: begin
        if (mul_running) next_state = EXEC;
        else             next_state = WRITE;
      end
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // op_a is shifted left and op_b right each iteration, so bit 0 of op_b is the current multiplier bit
  always_comb begin
    if (op_b[0]) mul_step = acc + op_a;
    else         mul_step = acc;
  end

  // Result selection from the latched operands
  always_comb begin
    alu_result = ZERO;
    case (op_lat)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_SHL:  alu_result = op_a << op_b[4:0];
      OP_MUL:  alu_result = mul_step;
      OP_SLT:  alu_result = ($signed(op_a) < $signed(op_b)) ? ONE : ZERO;
      default: alu_result = ZERO;
    endcase
  end

  // State, datapath and registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_lat      <= 3'b000;
      dst_lat     <= {ADDR_W{1'b0}};
      readAddrA   <= {ADDR_W{1'b0}};
      readAddrB   <= {ADDR_W{1'b0}};
      op_a        <= ZERO;
      op_b        <= ZERO;
      acc         <= ZERO;
      cnt         <= {CNT_W{1'b0}};
      writeAddr   <= {ADDR_W{1'b0}};
      writeData   <= ZERO;
      writeEnable <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      instReady   <= 1'b1;
    end else begin
      state       <= next_state;
      busy        <= (next_state != IDLE);
      instReady   <= (next_state == IDLE);
      writeEnable <= (next_state == WRITE);
      done        <= (next_state == WRITE);
      case (state)
        IDLE: begin
          if (instValid) begin
            op_lat    <= op;
            dst_lat   <= dst;
            readAddrA <= srcA;
            readAddrB <= srcB;
          end
        end
        READ: begin
          op_a <= rdA;
          op_b <= rdB;
          acc  <= ZERO;
          cnt  <= {CNT_W{1'b0}};
        end
        EXEC: begin
          if (mul_running) begin
            acc  <= mul_step;
            op_a <= op_a << 1;
            op_b <= op_b >> 1;
            cnt  <= cnt + CNT_ONE;
          end else begin
            writeData <= alu_result;
            writeAddr <= dst_lat;
          end
        end
        WRITE:   ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with a behavioural 8-entry register file.
module tb_alu_exec_stage;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SHL = 3'b101;
  localparam logic [2:0] MUL = 3'b110;
  localparam logic [2:0] SLT = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        instValid;
  logic        instReady;
  logic [2:0]  op;
  logic [2:0]  dst, srcA, srcB;
  logic [2:0]  readAddrA, readAddrB;
  logic [31:0] rdA, rdB;
  logic        writeEnable;
  logic [2:0]  writeAddr;
  logic [31:0] writeData;
  logic        busy;
  logic        done;

  logic [31:0] rf [8];
  logic        pre_we;
  logic [2:0]  pre_addr;
  logic [31:0] pre_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(32), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .instValid(instValid), .instReady(instReady),
    .op(op), .dst(dst), .srcA(srcA), .srcB(srcB),
    .readAddrA(readAddrA), .readAddrB(readAddrB), .rdA(rdA), .rdB(rdB),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .writeData(writeData),
    .busy(busy), .done(done)
  );

  // Register file: combinational read, posedge write, bench preload port
  assign rdA = rf[readAddrA];
  assign rdB = rf[readAddrB];
  always @(posedge clk) begin
    if (pre_we) rf[pre_addr] <= pre_data;
    else if (writeEnable) rf[writeAddr] <= writeData;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called in the negedge phase; returns in the negedge phase
  task automatic preload(input logic [2:0] a, input logic [31:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Issues one instruction from IDLE and checks timing, status and the written value
  task automatic run(input string tag, input logic [2:0] o, input logic [2:0] d,
                     input logic [2:0] a, input logic [2:0] b, input logic [31:0] exp);
    int lat, we_at, we_cnt, bad_busy, bad_done, bad_rdy;
    lat = (o == MUL) ? 33 : 2;
    we_at = -1; we_cnt = 0; bad_busy = 0; bad_done = 0; bad_rdy = 0;
    instValid = 1'b1; op = o; dst = d; srcA = a; srcB = b;
    for (int j = 0; j <= lat + 2; j++) begin
      @(negedge clk);
      if (j == 0) instValid = 1'b0;
      if (writeEnable === 1'b1) begin
        we_cnt++;
        if (we_at < 0) we_at = j;
      end
      if (done !== writeEnable) bad_done++;
      if (busy !== (j <= lat)) bad_busy++;
      if (instReady !== (j > lat)) bad_rdy++;
    end
    check({tag, "_we_cycle"}, 32'(we_at), 32'(lat));
    check({tag, "_we_count"}, 32'(we_cnt), 32'd1);
    check({tag, "_busy"},     32'(bad_busy), 32'd0);
    check({tag, "_ready"},    32'(bad_rdy), 32'd0);
    check({tag, "_done"},     32'(bad_done), 32'd0);
    check({tag, "_waddr"},    {29'd0, writeAddr}, {29'd0, d});
    check({tag, "_wdata"},    writeData, exp);
    check({tag, "_rf"},       rf[d], exp);
  endtask

  initial begin
    int we_cnt, we1, we2, bad_busy;
    reset = 1'b1; instValid = 1'b0; op = 3'b000; dst = 3'd0; srcA = 3'd0; srcB = 3'd0;
    pre_we = 1'b0; pre_addr = 3'd0; pre_data = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, instReady}, 32'd1);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_we",    {31'd0, writeEnable}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_wdata", writeData, 32'd0);
    reset = 1'b0;

    preload(3'd0, 32'hFEDCBA98);
    preload(3'd1, 32'h12345678);
    preload(3'd3, 32'h00000005);
    preload(3'd4, 32'h00000007);
    preload(3'd6, 32'h0000FFFF);
    preload(3'd7, 32'h0000FFFF);

    run("add",     ADD, 3'd2, 3'd0, 3'd1, 32'h11111110);
    run("sub",     SUB, 3'd5, 3'd3, 3'd4, 32'hFFFFFFFE);
    run("slt_lt",  SLT, 3'd5, 3'd3, 3'd4, 32'h00000001);
    run("slt_ge",  SLT, 3'd5, 3'd4, 3'd3, 32'h00000000);
    run("and",     AND, 3'd2, 3'd0, 3'd1, 32'h12141218);
    run("or",      OR,  3'd2, 3'd0, 3'd1, 32'hFEFCFEF8);
    run("xor",     XOR, 3'd2, 3'd0, 3'd1, 32'hECE8ECE0);
    run("shl",     SHL, 3'd5, 3'd1, 3'd3, 32'h468ACF00);
    run("mul",     MUL, 3'd6, 3'd6, 3'd7, 32'hFFFE0001);

    // Back-to-back with instValid held: second ADD must be accepted at E4
    we_cnt = 0; we1 = -1; we2 = -1;
    instValid = 1'b1; op = ADD; dst = 3'd2; srcA = 3'd0; srcB = 3'd1;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 0) begin dst = 3'd3; srcA = 3'd2; srcB = 3'd2; end
      if (j == 3) check("b2b_ready_e3", {31'd0, instReady}, 32'd1);
      if (j == 4) begin
        check("b2b_busy_e4", {31'd0, busy}, 32'd1);
        check("b2b_raddr_e4", {29'd0, readAddrA}, 32'd2);
        instValid = 1'b0;
      end
      if (writeEnable === 1'b1) begin
        we_cnt++;
        if (we1 < 0) we1 = j; else we2 = j;
      end
    end
    check("b2b_we_count", 32'(we_cnt), 32'd2);
    check("b2b_we1", 32'(we1), 32'd2);
    check("b2b_we2", 32'(we2), 32'd6);
    check("b2b_r2", rf[2], 32'h11111110);
    check("b2b_r3", rf[3], 32'h22222220);

    // instValid pulsed during EXEC must be ignored
    we_cnt = 0; we1 = -1; bad_busy = 0;
    instValid = 1'b1; op = ADD; dst = 3'd5; srcA = 3'd1; srcB = 3'd3;
    for (int j = 0; j <= 8; j++) begin
      @(negedge clk);
      if (j == 0) instValid = 1'b0;
      if (j == 1) begin instValid = 1'b1; op = SUB; dst = 3'd4; srcA = 3'd0; srcB = 3'd0; end
      if (j == 2) instValid = 1'b0;
      if (writeEnable === 1'b1) begin
        we_cnt++;
        if (we1 < 0) we1 = j;
      end
      if (j >= 3 && busy !== 1'b0) bad_busy++;
    end
    check("pulse_we_count", 32'(we_cnt), 32'd1);
    check("pulse_we_cycle", 32'(we1), 32'd2);
    check("pulse_idle", 32'(bad_busy), 32'd0);
    check("pulse_r5", rf[5], 32'h34567898);
    check("pulse_r4", rf[4], 32'h00000007);

    // Reset at MUL iteration 10 aborts with no write; instValid in reset cycle not accepted
    instValid = 1'b1; op = MUL; dst = 3'd7; srcA = 3'd7; srcB = 3'd7;
    for (int j = 0; j <= 11; j++) begin
      @(negedge clk);
      if (j == 0) instValid = 1'b0;
    end
    reset = 1'b1; instValid = 1'b1; op = ADD; dst = 3'd2; srcA = 3'd0; srcB = 3'd1;
    @(negedge clk);
    reset = 1'b0; instValid = 1'b0;
    check("abort_ready", {31'd0, instReady}, 32'd1);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_we",    {31'd0, writeEnable}, 32'd0);
    check("abort_done",  {31'd0, done}, 32'd0);
    check("abort_raddr", {26'd0, readAddrA, readAddrB}, 32'd0);
    check("abort_waddr", {29'd0, writeAddr}, 32'd0);
    check("abort_wdata", writeData, 32'd0);
    @(negedge clk);
    check("abort_no_accept", {31'd0, busy}, 32'd0);
    we_cnt = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (writeEnable !== 1'b0) we_cnt++;
    end
    check("abort_no_write", 32'(we_cnt), 32'd0);
    check("abort_r7", rf[7], 32'h0000FFFF);

    preload(3'd3, 32'h80000000);
    preload(3'd4, 32'h00000001);
    run("slt_neg", SLT, 3'd5, 3'd3, 3'd4, 32'h00000001);
    preload(3'd4, 32'h00000021);
    run("shl_mask", SHL, 3'd5, 3'd1, 3'd4, 32'h2468ACF0);
    run("mul_wrap", MUL, 3'd2, 3'd4, 3'd3, 32'h80000000);
    run("add_same", ADD, 3'd1, 3'd1, 3'd1, 32'h2468ACF0);
    run("sub_r0",   SUB, 3'd0, 3'd0, 3'd0, 32'h00000000);
    run("add_r0",   ADD, 3'd0, 3'd1, 3'd6, 32'h2466ACF1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
